mcpu_core: RTL and testbench
============================

# mcpu_core

Parametrised multicycle accumulator processor core, the next generation of the team's 16-bit/8-bit simplified processor. Width, address space and reset vector are parameters, and the instruction set gains SUB, AND, JZ and HALT. A request/ready memory handshake replaces the fixed-latency memory, so wait-state memories are supported. The core sits between the top-level project wrapper and a single shared instruction/data RAM.

## Interface
- DATA_W, 16, data/instruction width; must satisfy DATA_W >= ADDR_W+4.
- ADDR_W, 8, memory address width.
- RESET_PC, 0, PC value loaded on reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset).
- mem_req  out  1  memory request, held until ready.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  DATA_W  write data (AC).
- mem_rdata  in  DATA_W  read data, sampled when mem_req && mem_ready.
- mem_ready  in  1  transfer completes in a cycle where mem_req && mem_ready.
- halted  out  1  core in HALT state.
- illegal  out  1  sticky; set on an undefined opcode.
- state  out  4  current FSM state (debug/bench display).

## Operation
- Instruction format: opcode = IR[DATA_W-1:DATA_W-4]; operand address = IR[ADDR_W-1:0]; other bits ignored.
- Opcodes:
  - 0 ADD
  - 1 OR
  - 2 LOAD
  - 3 STORE
  - 4 JUMP
  - 5 MUL (AC <= low DATA_W bits of AC*M)
  - 6 SUB (AC-M, mod 2^DATA_W)
  - 7 AND
  - 8 JZ (jump if AC==0)
  - 9 HALT
  - 10–15 illegal
- Registers: PC (ADDR_W bits), IR, MDR, AC (DATA_W bits each).
- All outputs are registered. Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0, state=FETCH1. Reset also sets PC=RESET_PC and clears IR, MDR and AC.
- State encoding: 0 FETCH1, 1 FETCH2, 2 FETCH3, 3 DECODE, 4 EXEC_RD, 5 EXEC_WB, 6 EXEC_STORE, 7 EXEC_JUMP, 8 HALT; 9–15 unused, decoded as FETCH1.
- FETCH1: mem_addr<=PC, mem_we<=0, mem_req<=1; go to FETCH2.
- FETCH2: wait for mem_ready. On ready: MDR<=mem_rdata, mem_req<=0, PC<=PC+1 (wraps mod 2^ADDR_W); go to FETCH3.
- FETCH3: IR<=MDR; go to DECODE.
- DECODE:
  - ALU ops/LOAD: mem_addr<=operand, mem_req<=1; go to EXEC_RD.
  - STORE: mem_addr<=operand, mem_wdata<=AC, mem_we<=1, mem_req<=1; go to EXEC_STORE.
  - JUMP, or JZ with AC==0: go to EXEC_JUMP.
  - JZ with AC!=0: go to FETCH1.
  - HALT: go to HALT.
  - Illegal: illegal<=1; go to FETCH1 (executes as NOP).
- EXEC_RD: wait for mem_ready. On ready: MDR<=mem_rdata, mem_req<=0; go to EXEC_WB.
- EXEC_WB: AC<=alu(op, AC, MDR), where LOAD passes MDR; go to FETCH1.
- EXEC_STORE: wait for mem_ready. On ready: mem_req<=0, mem_we<=0; go to FETCH1.
- EXEC_JUMP: PC<=operand; go to FETCH1.
- HALT: terminal; halted=1, mem_req=0. Only reset exits.

## Timing
- Cycles per instruction with mem_ready tied to 1:
  - ADD/OR/LOAD/MUL/SUB/AND: 6
  - STORE, JUMP, taken JZ: 5
  - untaken JZ, illegal: 4
  - HALT: 4 cycles to reach the HALT state
- Each cycle with mem_req=1 and mem_ready=0 adds exactly one cycle. mem_addr, mem_we and mem_wdata stay stable throughout.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-transaction drops mem_req asynchronously. Memory must abandon the access; a write interrupted before ready need not complete.
- An AC result is visible to the next instruction's DECODE (JZ tests the post-update AC).

## Structure
- Package mcpu_pkg: opcode constants, state encoding (4-bit), and ALU op selector type.
- Sub-module mcpu_alu: combinational; (op, a, b) -> DATA_W result; parametrised on DATA_W.
- Core FSM and datapath stay in mcpu_core.

## Test plan
- Defaults, zero-wait memory. Program:
  - mem[0]=2010 (LOAD 0x10)
  - mem[1]=0011 (ADD 0x11)
  - mem[2]=5012 (MUL 0x12)
  - mem[3]=3013 (STORE 0x13)
  - mem[4]=9000 (HALT)
  - data: mem[10]=5, mem[11]=7, mem[12]=3
  - Required: mem[13]=0x0024, AC=0x0024, halted=1 after exactly 27 cycles from reset release.
- Same program with mem_ready low for 2 cycles on every access: identical final memory and AC; 9 accesses × 2 = 18 extra cycles (45 total).
- JZ coverage, both branches:
  - AC=0, mem[5]=8020: PC=0x20 next.
  - AC=1, same instruction: PC=6 next.
  - SUB 0x10 with AC=5 and mem[10]=5 yields AC=0.
- Opcode 0xF at mem[0]: illegal=1 and stays set; PC=1; execution continues. A later LOAD still works.
- RESET_PC=0xFF, mem[FF]=2010: after the fetch, PC wraps to 0x00 and the next fetch address is 0x00.
- DATA_W=24, ADDR_W=12:
  - AC=0x001000, MUL by 0x001000: AC=0x000000 (truncated), then JZ is taken.
  - Reset pulse during a stalled STORE: mem_req drops the same cycle; outputs return to reset values.

Source files
------------

// File: rtl/mcpu_pkg.sv
// mcpu shared definitions: opcodes, FSM state encoding, ALU selector.
// Imported by the core and its ALU.
package mcpu_pkg;

   typedef enum logic [3:0] {
      S_FETCH1     = 4'd0,
      S_FETCH2     = 4'd1,
      S_FETCH3     = 4'd2,
      S_DECODE     = 4'd3,
      S_EXEC_RD    = 4'd4,
      S_EXEC_WB    = 4'd5,
      S_EXEC_STORE = 4'd6,
      S_EXEC_JUMP  = 4'd7,
      S_HALT       = 4'd8
   } state_t;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_STORE = 4'd3;
   localparam logic [3:0] OP_JUMP  = 4'd4;
   localparam logic [3:0] OP_MUL   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_JZ    = 4'd8;
   localparam logic [3:0] OP_HALT  = 4'd9;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_OR,
      ALU_PASS,
      ALU_MUL,
      ALU_SUB,
      ALU_AND
   } alu_op_t;

   function automatic alu_op_t alu_sel(input logic [3:0] op);
      alu_op_t r;
      r = ALU_PASS;
      case (op)
         OP_ADD:  r = ALU_ADD;
         OP_OR:   r = ALU_OR;
         OP_MUL:  r = ALU_MUL;
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         default: r = ALU_PASS;
      endcase
      return r;
   endfunction

   // Opcodes that read a memory operand before writing AC.
   function automatic logic is_rd(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_OR) || (op == OP_LOAD) ||
             (op == OP_MUL) || (op == OP_SUB) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/mcpu_alu.sv
// mcpu accumulator ALU: purely combinational, result truncated
// to DATA_W bits (wraps for ADD/SUB/MUL).
module mcpu_alu
   import mcpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = b;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_OR:   y = a | b;
         ALU_MUL:  y = a * b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         default:  y = b;
      endcase
   end

endmodule

// File: rtl/mcpu_core.sv
// mcpu multicycle accumulator core with req/ready memory port.
// Every output comes straight from a register.
module mcpu_core
   import mcpu_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              illegal,
   output logic [3:0]        state
);

   localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

   state_t            st, st_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic [DATA_W-1:0] ir, ir_n;
   logic [DATA_W-1:0] mdr, mdr_n;
   logic [DATA_W-1:0] ac, ac_n;
   logic              req_n, we_n, ill_n, halt_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n;
   logic [DATA_W-1:0] alu_y;
   logic [3:0]        opc;
   logic [ADDR_W-1:0] opnd;
   logic              xfer;
   alu_op_t           aop;
   logic              unused_ir;

   assign opc       = ir[DATA_W-1 -: 4];
   assign opnd      = ir[ADDR_W-1:0];
   assign aop       = alu_sel(opc);
   assign xfer      = mem_req & mem_ready;
   assign state     = st;
   assign unused_ir = ^ir;

   mcpu_alu #(
      .DATA_W(DATA_W)
   ) u_alu (
      .op(aop),
      .a (ac),
      .b (mdr),
      .y (alu_y)
   );

   always_comb begin
      st_n    = st;
      pc_n    = pc;
      ir_n    = ir;
      mdr_n   = mdr;
      ac_n    = ac;
      req_n   = mem_req;
      we_n    = mem_we;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      ill_n   = illegal;
      halt_n  = halted;
      case (st)
         S_FETCH2: begin
            if (xfer) begin
               mdr_n = mem_rdata;
               req_n = 1'b0;
               pc_n  = pc + ADDR_W'(1);
               st_n  = S_FETCH3;
            end
         end
         S_FETCH3: begin
            ir_n = mdr;
            st_n = S_DECODE;
         end
         S_DECODE: begin
            unique case (1'b1)
               is_rd(opc): begin
                  addr_n = opnd;
                  req_n  = 1'b1;
                  st_n   = S_EXEC_RD;
               end
               (opc == OP_STORE): begin
                  addr_n  = opnd;
                  wdata_n = ac;
                  we_n    = 1'b1;
                  req_n   = 1'b1;
                  st_n    = S_EXEC_STORE;
               end
               (opc == OP_JUMP),
               (opc == OP_JZ && ac == '0):
                  st_n = S_EXEC_JUMP;
               (opc == OP_JZ && ac != '0):
                  st_n = S_FETCH1;
               (opc == OP_HALT): begin
                  st_n   = S_HALT;
                  halt_n = 1'b1;
               end
               default: begin
                  ill_n = 1'b1;
                  st_n  = S_FETCH1;
               end
            endcase
         end
         S_EXEC_RD: begin
            if (xfer) begin
               mdr_n = mem_rdata;
               req_n = 1'b0;
               st_n  = S_EXEC_WB;
            end
         end
         S_EXEC_WB: begin
            ac_n = alu_y;
            st_n = S_FETCH1;
         end
         S_EXEC_STORE: begin
            if (xfer) begin
               req_n = 1'b0;
               we_n  = 1'b0;
               st_n  = S_FETCH1;
            end
         end
         S_EXEC_JUMP: begin
            pc_n = opnd;
            st_n = S_FETCH1;
         end
         S_HALT: begin
            req_n  = 1'b0;
            halt_n = 1'b1;
         end
         // FETCH1, and any unused encoding recovers through it
         default: begin
            addr_n = pc;
            we_n   = 1'b0;
            req_n  = 1'b1;
            st_n   = S_FETCH2;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= S_FETCH1;
         pc        <= PC0;
         ir        <= '0;
         mdr       <= '0;
         ac        <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         illegal   <= 1'b0;
         halted    <= 1'b0;
      end else begin
         st        <= st_n;
         pc        <= pc_n;
         ir        <= ir_n;
         mdr       <= mdr_n;
         ac        <= ac_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         illegal   <= ill_n;
         halted    <= halt_n;
      end
   end

endmodule

// File: tb/tb_mcpu_core.sv
// mcpu_core bench: ISA-level reference model with random programs
// and wait states, plus directed reset-vector and 24-bit cases.
module tb_mcpu_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A: 16/8, RESET_PC=0 ----------------
   logic        a_rst = 1'b0;
   logic        a_ready = 1'b0;
   logic [15:0] a_rdata = '0;
   logic        a_req, a_we, a_halted, a_ill;
   logic [7:0]  a_addr;
   logic [15:0] a_wdata;
   logic [3:0]  a_state;

   mcpu_core u_a (
      .clk(clk), .rst(a_rst),
      .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
      .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
      .halted(a_halted), .illegal(a_ill), .state(a_state)
   );

   logic [15:0] mem_a [256];
   int          waits [1024];
   int          a_k = 0;
   int          a_left = 0;
   bit          a_busy = 0;
   logic [24:0] a_held, a_cur;
   logic [24:0] exp_q [$];

   logic [15:0] m_mem [256];
   int          m_cyc, m_nacc;
   logic        m_ill;
   int          last_cyc;

   // memory with per-access wait states taken from waits[]
   initial forever begin
      @(negedge clk);
      a_cur = {a_we, a_addr, a_we ? a_wdata : 16'h0};
      if (!a_rst) begin
         a_busy  = 0;
         a_ready = 1'b0;
      end else if (a_req) begin
         if (!a_busy) begin
            a_busy = 1;
            a_left = waits[a_k % 1024];
            a_held = a_cur;
         end
         chk("a_stable", a_cur, a_held);
         if (a_left > 0) begin
            a_left--;
            a_ready = 1'b0;
            a_rdata = 16'($urandom);
         end else begin
            a_ready = 1'b1;
            a_rdata = mem_a[a_addr];
            if (a_we) mem_a[a_addr] = a_wdata;
            if (exp_q.size() > 0)
               chk("a_acc", a_cur, exp_q.pop_front());
            else
               chk("a_acc_extra", a_k + 1, m_nacc);
            a_k++;
            a_busy = 0;
         end
      end else begin
         a_ready = 1'($urandom_range(0, 1));
         a_rdata = 16'($urandom);
      end
   end

   task automatic m_acc(input logic we, input logic [7:0] ad,
                        input logic [15:0] wd);
      exp_q.push_back({we, ad, we ? wd : 16'h0});
      m_cyc += waits[m_nacc % 1024];
      m_nacc++;
   endtask

   // instruction-level model: cycles per class plus memory waits
   task automatic model_a();
      logic [7:0]  pc, a;
      logic [15:0] ac, ir, v;
      logic [3:0]  op;
      bit          done;
      m_mem  = mem_a;
      pc     = 8'h00;
      ac     = 16'h0;
      m_cyc  = 0;
      m_nacc = 0;
      m_ill  = 1'b0;
      done   = 0;
      exp_q.delete();
      for (int s = 0; s < 500 && !done; s++) begin
         ir = m_mem[pc];
         m_acc(1'b0, pc, 16'h0);
         pc = pc + 8'd1;
         op = ir[15:12];
         a  = ir[7:0];
         if (op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7}) begin
            m_acc(1'b0, a, 16'h0);
            v = m_mem[a];
            case (op)
               4'd0:    ac = ac + v;
               4'd1:    ac = ac | v;
               4'd5:    ac = ac * v;
               4'd6:    ac = ac - v;
               4'd7:    ac = ac & v;
               default: ac = v;
            endcase
            m_cyc += 6;
         end else if (op == 4'd3) begin
            m_acc(1'b1, a, ac);
            m_mem[a] = ac;
            m_cyc += 5;
         end else if (op == 4'd4) begin
            pc = a;
            m_cyc += 5;
         end else if (op == 4'd8) begin
            if (ac == 16'h0) begin
               pc = a;
               m_cyc += 5;
            end else m_cyc += 4;
         end else if (op == 4'd9) begin
            m_cyc += 4;
            done = 1;
         end else begin
            m_ill = 1'b1;
            m_cyc += 4;
         end
      end
   endtask

   task automatic run_a(input string tag);
      int cyc;
      model_a();
      a_rst = 1'b0;
      a_k   = 0;
      repeat (2) @(negedge clk);
      a_rst = 1'b1;
      cyc = 0;
      while (!a_halted && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      last_cyc = cyc;
      chk({tag, "_cyc"}, cyc, m_cyc);
      chk({tag, "_halted"}, a_halted, 1'b1);
      chk({tag, "_state"}, a_state, 4'd8);
      chk({tag, "_req"}, a_req, 1'b0);
      chk({tag, "_ill"}, a_ill, m_ill);
      chk({tag, "_nacc"}, a_k, m_nacc);
      for (int i = 0; i < 256; i++)
         chk($sformatf("%s_mem%0h", tag, i), mem_a[i], m_mem[i]);
   endtask

   task automatic set_waits(input int mode);
      for (int i = 0; i < 1024; i++)
         waits[i] = (mode < 0) ? $urandom_range(0, 3) : mode;
   endtask

   task automatic clear_a();
      for (int i = 0; i < 256; i++) mem_a[i] = 16'h0;
   endtask

   task automatic load_demo();
      clear_a();
      mem_a[0]     = 16'h2010;
      mem_a[1]     = 16'h0011;
      mem_a[2]     = 16'h5012;
      mem_a[3]     = 16'h3013;
      mem_a[4]     = 16'h9000;
      mem_a[8'h10] = 16'd5;
      mem_a[8'h11] = 16'd7;
      mem_a[8'h12] = 16'd3;
   endtask

   task automatic load_jz(input bit taken);
      clear_a();
      mem_a[0]     = 16'h2018;
      mem_a[1]     = taken ? 16'h6010 : 16'h6019;
      mem_a[2]     = 16'h0014;
      mem_a[3]     = 16'h0014;
      mem_a[4]     = 16'h0014;
      mem_a[5]     = 16'h8020;
      mem_a[6]     = 16'h2016;
      mem_a[7]     = 16'h3031;
      mem_a[8]     = 16'h9000;
      mem_a[8'h20] = 16'h2015;
      mem_a[8'h21] = 16'h3031;
      mem_a[8'h22] = 16'h9000;
      mem_a[8'h10] = 16'd5;
      mem_a[8'h18] = 16'd5;
      mem_a[8'h19] = 16'd4;
      mem_a[8'h15] = 16'h00AA;
      mem_a[8'h16] = 16'h00BB;
   endtask

   // forward-only jumps in 0..31 so every program reaches HALT
   task automatic gen_prog();
      logic [3:0] op;
      logic [7:0] opd;
      int         r;
      for (int i = 0; i < 256; i++)
         mem_a[i] = ($urandom_range(0, 1) == 1) ?
                    16'($urandom_range(0, 3)) : 16'($urandom);
      for (int i = 0; i < 31; i++) begin
         r = $urandom_range(0, 22);
         opd = 8'($urandom_range(64, 127));
         if (r < 14) begin
            case (r % 7)
               0: op = 4'd0;
               1: op = 4'd1;
               2: op = 4'd2;
               3: op = 4'd3;
               4: op = 4'd5;
               5: op = 4'd6;
               default: op = 4'd7;
            endcase
         end else if (r < 19) begin
            op  = (r < 17) ? 4'd8 : 4'd4;
            opd = 8'($urandom_range(i + 1, 31));
         end else begin
            op = 4'($urandom_range(10, 15));
         end
         mem_a[i] = {op, 4'($urandom), opd};
      end
      mem_a[31] = {4'h9, 12'($urandom)};
   endtask

   // ---------------- instance B: RESET_PC=0xFF ----------------
   logic        b_rst = 1'b0;
   logic        b_ready = 1'b0;
   logic [15:0] b_rdata = '0;
   logic        b_req, b_we, b_halted, b_ill;
   logic [7:0]  b_addr;
   logic [15:0] b_wdata;
   logic [3:0]  b_state;
   logic [15:0] mem_b [256];
   logic [7:0]  b_trace [$];

   mcpu_core #(.RESET_PC(255)) u_b (
      .clk(clk), .rst(b_rst),
      .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
      .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
      .halted(b_halted), .illegal(b_ill), .state(b_state)
   );

   initial forever begin
      @(negedge clk);
      b_ready = b_req;
      b_rdata = mem_b[b_addr];
      if (b_req && !b_we && b_trace.size() < 8)
         b_trace.push_back(b_addr);
      if (b_req && b_we) mem_b[b_addr] = b_wdata;
   end

   // ---------------- instance C: 24/12 ----------------
   logic        c_rst = 1'b0;
   logic        c_ready = 1'b0;
   logic [23:0] c_rdata = '0;
   logic        c_req, c_we, c_halted, c_ill;
   logic [11:0] c_addr;
   logic [23:0] c_wdata;
   logic [3:0]  c_state;
   logic [23:0] mem_c [4096];
   bit          c_stall_wr = 0;

   mcpu_core #(.DATA_W(24), .ADDR_W(12)) u_c (
      .clk(clk), .rst(c_rst),
      .mem_req(c_req), .mem_we(c_we), .mem_addr(c_addr),
      .mem_wdata(c_wdata), .mem_rdata(c_rdata), .mem_ready(c_ready),
      .halted(c_halted), .illegal(c_ill), .state(c_state)
   );

   initial forever begin
      @(negedge clk);
      c_ready = c_req && !(c_we && c_stall_wr);
      c_rdata = mem_c[c_addr];
      if (c_ready && c_we) mem_c[c_addr] = c_wdata;
   end

   task automatic run_c(output int cyc);
      @(negedge clk);
      c_rst = 1'b1;
      cyc = 0;
      while (!c_halted && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      int cyc, t;

      // reset values
      set_waits(0);
      clear_a();
      repeat (2) @(negedge clk);
      chk("rst_req", a_req, 1'b0);
      chk("rst_we", a_we, 1'b0);
      chk("rst_addr", a_addr, 8'h00);
      chk("rst_wdata", a_wdata, 16'h0);
      chk("rst_halted", a_halted, 1'b0);
      chk("rst_ill", a_ill, 1'b0);
      chk("rst_state", a_state, 4'd0);

      // demo program, zero wait
      load_demo();
      run_a("demo0");
      chk("demo0_cyc27", last_cyc, 27);
      chk("demo0_m13", mem_a[8'h13], 16'h0024);

      // demo program, two wait cycles on every access
      load_demo();
      set_waits(2);
      run_a("demo2");
      chk("demo2_cyc45", last_cyc, 45);
      chk("demo2_m13", mem_a[8'h13], 16'h0024);
      set_waits(0);

      // JZ taken (SUB to zero) and untaken
      load_jz(1'b1);
      run_a("jz_t");
      chk("jz_t_res", mem_a[8'h31], 16'h00AA);
      load_jz(1'b0);
      run_a("jz_n");
      chk("jz_n_res", mem_a[8'h31], 16'h00BB);

      // illegal opcode executes as NOP, flag stays set
      clear_a();
      mem_a[0]     = 16'hF000;
      mem_a[1]     = 16'h2010;
      mem_a[2]     = 16'h3013;
      mem_a[3]     = 16'h9000;
      mem_a[8'h10] = 16'h0055;
      run_a("ill");
      chk("ill_flag", a_ill, 1'b1);
      chk("ill_m13", mem_a[8'h13], 16'h0055);
      chk("ill_cyc19", last_cyc, 19);

      // random programs with random wait states
      for (int n = 0; n < 12; n++) begin
         gen_prog();
         set_waits((n % 3 == 0) ? 0 : -1);
         run_a($sformatf("rnd%0d", n));
      end

      // reset vector 0xFF wraps to 0x00
      for (int i = 0; i < 256; i++) mem_b[i] = 16'h0;
      mem_b[8'hFF] = 16'h2010;
      mem_b[8'h00] = 16'h3011;
      mem_b[8'h01] = 16'h9000;
      mem_b[8'h10] = 16'h1234;
      b_trace.delete();
      @(negedge clk);
      b_rst = 1'b1;
      t = 0;
      while (!b_halted && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("b_halted", b_halted, 1'b1);
      chk("b_ntrace", b_trace.size(), 4);
      if (b_trace.size() == 4) begin
         chk("b_f0", b_trace[0], 8'hFF);
         chk("b_rd", b_trace[1], 8'h10);
         chk("b_f1", b_trace[2], 8'h00);
         chk("b_f2", b_trace[3], 8'h01);
      end
      chk("b_m11", mem_b[8'h11], 16'h1234);

      // 24-bit: truncating MUL then taken JZ
      for (int i = 0; i < 4096; i++) mem_c[i] = 24'h0;
      mem_c[0]      = 24'h200100;
      mem_c[1]      = 24'h500101;
      mem_c[2]      = 24'h800200;
      mem_c[3]      = 24'h200102;
      mem_c[4]      = 24'h300300;
      mem_c[5]      = 24'h900000;
      mem_c[12'h200] = 24'h300300;
      mem_c[12'h201] = 24'h900000;
      mem_c[12'h100] = 24'h001000;
      mem_c[12'h101] = 24'h001000;
      mem_c[12'h102] = 24'h123456;
      mem_c[12'h300] = 24'hABCDEF;
      run_c(cyc);
      chk("c_halted", c_halted, 1'b1);
      chk("c_cyc", cyc, 26);
      chk("c_m300", mem_c[12'h300], 24'h000000);

      // reset pulse during a stalled STORE
      c_rst = 1'b0;
      mem_c[0]       = 24'h200102;
      mem_c[1]       = 24'h300301;
      mem_c[2]       = 24'h900000;
      mem_c[12'h301] = 24'h00BEEF;
      c_stall_wr = 1;
      @(negedge clk);
      c_rst = 1'b1;
      t = 0;
      while (!(c_req && c_we) && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("c_st_seen", {c_req, c_we}, 2'b11);
      repeat (3) @(posedge clk);
      #1;
      chk("c_st_req", c_req, 1'b1);
      chk("c_st_addr", c_addr, 12'h301);
      chk("c_st_wdata", c_wdata, 24'h123456);
      chk("c_st_state", c_state, 4'd6);
      @(posedge clk);
      #3;
      c_rst = 1'b0;
      #1;
      chk("c_ar_req", c_req, 1'b0);
      chk("c_ar_we", c_we, 1'b0);
      chk("c_ar_addr", c_addr, 12'h000);
      chk("c_ar_wdata", c_wdata, 24'h0);
      chk("c_ar_halted", c_halted, 1'b0);
      chk("c_ar_ill", c_ill, 1'b0);
      chk("c_ar_state", c_state, 4'd0);
      repeat (2) @(negedge clk);
      chk("c_ar_mem", mem_c[12'h301], 24'h00BEEF);
      c_stall_wr = 0;
      run_c(cyc);
      chk("c_re_cyc", cyc, 15);
      chk("c_re_mem", mem_c[12'h301], 24'h123456);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
